// File: rtl/ctrl_mc_if.sv
// Controller <-> datapath bundle for ctrl_mc: instruction fields and status in,
// datapath strobes, halt flag and retired-instruction count out.
interface ctrl_mc_if #(
    parameter int OP_W   = 4,
    parameter int STAT_W = 4,
    parameter int CNT_W  = 16
);
    logic [OP_W-1:0]   opcode;
    logic [STAT_W-1:0] mm;
    logic [STAT_W-1:0] stat;
    logic              mem_rdy;

    logic              ir_we;
    logic              pc_we;
    logic              pc_sel;
    logic              rd_sel;
    logic              alu_op;
    logic              alu_imm;
    logic              mem_we;
    logic              rf_we;
    logic              wb_sel;
    logic              halted;
    logic [CNT_W-1:0]  retired;

    // master = the controller, slave = the datapath it steers
    modport master (
        input  opcode, mm, stat, mem_rdy,
        output ir_we, pc_we, pc_sel, rd_sel, alu_op, alu_imm,
               mem_we, rf_we, wb_sel, halted, retired
    );

    modport slave (
        output opcode, mm, stat, mem_rdy,
        input  ir_we, pc_we, pc_sel, rd_sel, alu_op, alu_imm,
               mem_we, rf_we, wb_sel, halted, retired
    );
endinterface

// File: rtl/ctrl_mc.sv
// Multicycle instruction sequencer: walks FETCH/DECODE/EXECUTE/MEM/WRITEBACK,
// drives datapath strobes, resolves branches, latches HALT, counts retirements.
//
// state     | meaning
// ----------+-------------------------------------------------
// START0    | reset landing state, all strobes idle
// START1    | one settle cycle before the first fetch
// FETCH     | load IR and PC+1 once memory is ready
// DECODE    | select register-read port (Rd for STR)
// EXECUTE   | ALU operation or branch resolution
// MEM       | data-memory access, stalls on MEM_RDY for LOD/STR
// WRITEBACK | register-file write from ALU or memory
// HALT      | absorbing stop state, left only through reset
module ctrl_mc #(
    parameter int          OP_W    = 4,
    parameter int          STAT_W  = 4,
    parameter int unsigned SKIP_EN = 1,
    parameter int          CNT_W   = 16
) (
    input  logic     i_clk,
    input  logic     i_rst,
    ctrl_mc_if.master bus
);

    typedef enum logic [2:0] {
        S_START0    = 3'd0,
        S_START1    = 3'd1,
        S_FETCH     = 3'd2,
        S_DECODE    = 3'd3,
        S_EXECUTE   = 3'd4,
        S_MEM       = 3'd5,
        S_WRITEBACK = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [OP_W-1:0] OPC_LOD = OP_W'(1);
    localparam logic [OP_W-1:0] OPC_STR = OP_W'(2);
    localparam logic [OP_W-1:0] OPC_BRA = OP_W'(4);
    localparam logic [OP_W-1:0] OPC_BRR = OP_W'(5);
    localparam logic [OP_W-1:0] OPC_BNE = OP_W'(6);
    localparam logic [OP_W-1:0] OPC_ALU = OP_W'(8);
    localparam logic [OP_W-1:0] OPC_HLT = OP_W'(15);
    localparam logic [STAT_W-1:0] MM_IMM = STAT_W'(8);
    localparam logic w_skip = (SKIP_EN != 0);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_retired;

    logic w_is_lod;
    logic w_is_str;
    logic w_is_alu;
    logic w_is_bra;
    logic w_is_bne;
    logic w_is_hlt;
    logic w_is_mem;
    logic w_bne_take;
    logic w_retire;

    // Unlisted opcodes decode to nothing and therefore behave as NOOP
    assign w_is_lod   = (bus.opcode == OPC_LOD);
    assign w_is_str   = (bus.opcode == OPC_STR);
    assign w_is_alu   = (bus.opcode == OPC_ALU);
    assign w_is_bra   = (bus.opcode == OPC_BRA) || (bus.opcode == OPC_BRR);
    assign w_is_bne   = (bus.opcode == OPC_BNE);
    assign w_is_hlt   = (bus.opcode == OPC_HLT);
    assign w_is_mem   = w_is_lod || w_is_str;
    assign w_bne_take = ((bus.stat & bus.mm) == '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_START0:    w_next = S_START1;
            S_START1:    w_next = S_FETCH;
            S_FETCH:     if (bus.mem_rdy) w_next = S_DECODE;
            S_DECODE:    w_next = w_is_hlt ? S_HALT : S_EXECUTE;
            S_EXECUTE: begin
                if (!w_skip || w_is_mem) w_next = S_MEM;
                else if (w_is_alu)       w_next = S_WRITEBACK;
                else                     w_next = S_FETCH;
            end
            S_MEM: begin
                if (w_is_mem && !bus.mem_rdy) w_next = S_MEM;
                else if (!w_skip || w_is_lod) w_next = S_WRITEBACK;
                else                          w_next = S_FETCH;
            end
            S_WRITEBACK: w_next = S_FETCH;
            S_HALT:      w_next = S_HALT;
        endcase
    end

    // START1 -> FETCH is not a completed instruction, so only the tail states count
    assign w_retire = (w_next == S_FETCH) &&
                      ((r_state == S_EXECUTE) || (r_state == S_MEM) ||
                       (r_state == S_WRITEBACK));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_START0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire && (r_retired != {CNT_W{1'b1}}))
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        bus.ir_we   = 1'b0;
        bus.pc_we   = 1'b0;
        bus.pc_sel  = 1'b0;
        bus.rd_sel  = 1'b0;
        bus.alu_op  = 1'b0;
        bus.alu_imm = 1'b0;
        bus.mem_we  = 1'b0;
        bus.rf_we   = 1'b0;
        bus.wb_sel  = 1'b0;
        bus.halted  = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.ir_we = bus.mem_rdy;
                bus.pc_we = bus.mem_rdy;
            end
            S_DECODE: bus.rd_sel = w_is_str;
            S_EXECUTE: begin
                bus.alu_op  = w_is_alu;
                bus.alu_imm = w_is_alu && (bus.mm == MM_IMM);
                bus.pc_we   = w_is_bra || (w_is_bne && w_bne_take);
                bus.pc_sel  = w_is_bra || (w_is_bne && w_bne_take);
            end
            S_MEM: bus.mem_we = w_is_str && bus.mem_rdy;
            S_WRITEBACK: begin
                bus.rf_we  = w_is_alu || w_is_lod;
                bus.wb_sel = w_is_lod;
            end
            S_HALT: bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.retired = r_retired;

endmodule

// File: tb/tb_ctrl_mc.sv
// Directed bench for ctrl_mc: a skip-mode core and a full-walk 4-bit-counter core
// driven cycle by cycle against hand-derived strobe patterns.
module tb_ctrl_mc;

    localparam logic [9:0] IR = 10'h200;
    localparam logic [9:0] PW = 10'h100;
    localparam logic [9:0] PS = 10'h080;
    localparam logic [9:0] RD = 10'h040;
    localparam logic [9:0] AO = 10'h020;
    localparam logic [9:0] AI = 10'h010;
    localparam logic [9:0] MW = 10'h008;
    localparam logic [9:0] RF = 10'h004;
    localparam logic [9:0] WB = 10'h002;
    localparam logic [9:0] HL = 10'h001;

    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_LOD  = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd2;
    localparam logic [3:0] OP_BRA  = 4'd4;
    localparam logic [3:0] OP_BRR  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_ALU  = 4'd8;
    localparam logic [3:0] OP_HLT  = 4'd15;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic [3:0] op;
    logic [3:0] mm;
    logic [3:0] stat;
    logic       rdy;
    int         n_assert = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    ctrl_mc_if #(.OP_W(4), .STAT_W(4), .CNT_W(16)) bus_a ();
    ctrl_mc_if #(.OP_W(4), .STAT_W(4), .CNT_W(4))  bus_b ();

    assign bus_a.opcode  = op;
    assign bus_a.mm      = mm;
    assign bus_a.stat    = stat;
    assign bus_a.mem_rdy = rdy;
    assign bus_b.opcode  = op;
    assign bus_b.mm      = mm;
    assign bus_b.stat    = stat;
    assign bus_b.mem_rdy = rdy;

    ctrl_mc #(.OP_W(4), .STAT_W(4), .SKIP_EN(1), .CNT_W(16)) dut_a (
        .i_clk (clk),
        .i_rst (rst_a),
        .bus   (bus_a)
    );

    ctrl_mc #(.OP_W(4), .STAT_W(4), .SKIP_EN(0), .CNT_W(4)) dut_b (
        .i_clk (clk),
        .i_rst (rst_b),
        .bus   (bus_b)
    );

    wire [9:0] strb_a = {bus_a.ir_we, bus_a.pc_we, bus_a.pc_sel, bus_a.rd_sel, bus_a.alu_op,
                         bus_a.alu_imm, bus_a.mem_we, bus_a.rf_we, bus_a.wb_sel, bus_a.halted};
    wire [9:0] strb_b = {bus_b.ir_we, bus_b.pc_we, bus_b.pc_sel, bus_b.rd_sel, bus_b.alu_op,
                         bus_b.alu_imm, bus_b.mem_we, bus_b.rf_we, bus_b.wb_sel, bus_b.halted};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, check strobes before the edge, then advance past it
    task automatic cyc(input int which, input logic [3:0] o, input logic [3:0] m,
                       input logic [3:0] s, input logic r, input logic [9:0] exp,
                       input string tag);
        op   = o;
        mm   = m;
        stat = s;
        rdy  = r;
        #1;
        check(tag, (which == 0) ? {22'd0, strb_a} : {22'd0, strb_b}, {22'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        op    = OP_NOOP;
        mm    = 4'd0;
        stat  = 4'd0;
        rdy   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;

        check("a_rst_ret", {16'd0, bus_a.retired}, 32'd0);
        cyc(0, OP_NOOP, 0, 0, 1, 10'd0, "a_start0");
        cyc(0, OP_NOOP, 0, 0, 1, 10'd0, "a_start1");
        check("a_ret0", {16'd0, bus_a.retired}, 32'd0);

        cyc(0, OP_ALU, 8, 0, 1, IR | PW, "alu_fetch");
        cyc(0, OP_ALU, 8, 0, 1, 10'd0,   "alu_dec");
        cyc(0, OP_ALU, 8, 0, 1, AO | AI, "alu_exe");
        cyc(0, OP_ALU, 8, 0, 1, RF,      "alu_wb");
        check("ret_alu", {16'd0, bus_a.retired}, 32'd1);

        cyc(0, OP_LOD, 0, 0, 1, IR | PW, "lod_fetch");
        cyc(0, OP_LOD, 0, 0, 1, 10'd0,   "lod_dec");
        cyc(0, OP_LOD, 0, 0, 1, 10'd0,   "lod_exe");
        cyc(0, OP_LOD, 0, 0, 1, 10'd0,   "lod_mem");
        cyc(0, OP_LOD, 0, 0, 1, RF | WB, "lod_wb");
        check("ret_lod", {16'd0, bus_a.retired}, 32'd2);

        cyc(0, OP_STR, 0, 0, 1, IR | PW, "str_fetch");
        cyc(0, OP_STR, 0, 0, 1, RD,      "str_dec");
        cyc(0, OP_STR, 0, 0, 1, 10'd0,   "str_exe");
        cyc(0, OP_STR, 0, 0, 1, MW,      "str_mem");
        check("ret_str", {16'd0, bus_a.retired}, 32'd3);

        cyc(0, OP_NOOP, 8, 0, 1, IR | PW, "noop_fetch");
        cyc(0, OP_NOOP, 8, 0, 1, 10'd0,   "noop_dec");
        cyc(0, OP_NOOP, 8, 0, 1, 10'd0,   "noop_exe");
        check("ret_noop", {16'd0, bus_a.retired}, 32'd4);

        cyc(0, OP_ALU, 3, 0, 1, IR | PW, "alu3_fetch");
        cyc(0, OP_ALU, 3, 0, 1, 10'd0,   "alu3_dec");
        cyc(0, OP_ALU, 3, 0, 1, AO,      "alu3_exe");
        cyc(0, OP_ALU, 3, 0, 1, RF,      "alu3_wb");
        check("ret_alu3", {16'd0, bus_a.retired}, 32'd5);

        cyc(0, OP_BNE, 1, 0, 1, IR | PW, "bne_t_fetch");
        cyc(0, OP_BNE, 1, 0, 1, 10'd0,   "bne_t_dec");
        cyc(0, OP_BNE, 1, 0, 1, PW | PS, "bne_taken");
        cyc(0, OP_BNE, 1, 1, 1, IR | PW, "bne_n_fetch");
        cyc(0, OP_BNE, 1, 1, 1, 10'd0,   "bne_n_dec");
        cyc(0, OP_BNE, 1, 1, 1, 10'd0,   "bne_not_taken");
        check("ret_bne", {16'd0, bus_a.retired}, 32'd7);

        cyc(0, OP_BRA, 1, 1, 1, IR | PW, "bra_fetch");
        cyc(0, OP_BRA, 1, 1, 1, 10'd0,   "bra_dec");
        cyc(0, OP_BRA, 1, 1, 1, PW | PS, "bra_exe");
        cyc(0, OP_BRR, 0, 15, 1, IR | PW, "brr_fetch");
        cyc(0, OP_BRR, 0, 15, 1, 10'd0,   "brr_dec");
        cyc(0, OP_BRR, 0, 15, 1, PW | PS, "brr_exe");
        cyc(0, 4'd3, 8, 0, 1, IR | PW, "unk_fetch");
        cyc(0, 4'd3, 8, 0, 1, 10'd0,   "unk_dec");
        cyc(0, 4'd3, 8, 0, 1, 10'd0,   "unk_exe");
        check("ret_br", {16'd0, bus_a.retired}, 32'd10);

        cyc(0, OP_STR, 0, 0, 1, IR | PW, "stl_fetch");
        cyc(0, OP_STR, 0, 0, 1, RD,      "stl_dec");
        cyc(0, OP_STR, 0, 0, 1, 10'd0,   "stl_exe");
        for (int i = 0; i < 3; i++)
            cyc(0, OP_STR, 0, 0, 0, 10'd0, "stl_mem_wait");
        cyc(0, OP_STR, 0, 0, 1, MW, "stl_mem_rdy");
        check("ret_stl", {16'd0, bus_a.retired}, 32'd11);

        for (int i = 0; i < 2; i++)
            cyc(0, OP_ALU, 0, 0, 0, 10'd0, "fstl_wait");
        cyc(0, OP_ALU, 0, 0, 1, IR | PW, "fstl_rdy");
        cyc(0, OP_ALU, 0, 0, 1, 10'd0,   "fstl_dec");
        cyc(0, OP_ALU, 0, 0, 1, AO,      "fstl_exe");
        cyc(0, OP_ALU, 0, 0, 1, RF,      "fstl_wb");
        check("ret_fstl", {16'd0, bus_a.retired}, 32'd12);

        cyc(0, OP_HLT, 0, 0, 1, IR | PW, "hlt_fetch");
        cyc(0, OP_HLT, 0, 0, 1, 10'd0,   "hlt_dec");
        for (int i = 0; i < 20; i++) begin
            cyc(0, 4'(i * 5), 4'(i), 4'(15 - i), 1'(i), HL, "halt_hold");
            check("halt_ret", {16'd0, bus_a.retired}, 32'd12);
        end
        rst_a = 1'b1;
        cyc(0, OP_HLT, 0, 0, 1, HL, "halt_pre_rst");
        rst_a = 1'b0;
        check("halt_rst_ret", {16'd0, bus_a.retired}, 32'd0);
        cyc(0, OP_HLT, 0, 0, 1, 10'd0, "halt_rst_s0");

        cyc(0, OP_STR, 0, 0, 1, 10'd0,   "ab_start1");
        cyc(0, OP_STR, 0, 0, 1, IR | PW, "ab_fetch");
        cyc(0, OP_STR, 0, 0, 1, RD,      "ab_dec");
        cyc(0, OP_STR, 0, 0, 1, 10'd0,   "ab_exe");
        rst_a = 1'b1;
        cyc(0, OP_STR, 0, 0, 0, 10'd0, "ab_mem_wait");
        rst_a = 1'b0;
        cyc(0, OP_STR, 0, 0, 1, 10'd0, "ab_after_rst");
        check("ab_ret", {16'd0, bus_a.retired}, 32'd0);

        rst_b = 1'b0;
        cyc(1, OP_NOOP, 0, 0, 1, 10'd0, "b_start0");
        cyc(1, OP_NOOP, 0, 0, 1, 10'd0, "b_start1");
        for (int i = 0; i < 20; i++) begin
            logic [3:0] o;
            o = (i == 0) ? OP_STR : ((i == 1) ? OP_ALU : OP_NOOP);
            check("b_ret", {28'd0, bus_b.retired}, (i > 15) ? 32'd15 : 32'(i));
            cyc(1, o, 0, 0, 1, IR | PW,                    "b_fetch");
            cyc(1, o, 0, 0, 1, (i == 0) ? RD : 10'd0,      "b_dec");
            cyc(1, o, 0, 0, 1, (i == 1) ? AO : 10'd0,      "b_exe");
            cyc(1, o, 0, 0, 1, (i == 0) ? MW : 10'd0,      "b_mem");
            cyc(1, o, 0, 0, 1, (i == 1) ? RF : 10'd0,      "b_wb");
        end
        check("b_ret_sat", {28'd0, bus_b.retired}, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
